// File: rtl/gpio_event_arbiter.sv
// gpio_event_arbiter
//
// Turns GPIO pin activity into a stream of edge events. Each raw pin passes
// through a two-flop synchronizer and a debouncer. Each accepted edge that its
// enable allows is held as a pending event. A round-robin arbiter then offers
// the pending events, one at a time, on a single valid/ready port.
//
// Ports
//   i_clk            system clock
//   i_rst_n          asynchronous active-low reset
//   i_async          raw pin inputs, one bit per channel
//   i_rise_en        per-channel enable for rising-edge events
//   i_fall_en        per-channel enable for falling-edge events
//   o_level          debounced pin levels
//   o_evt_valid      an event is being offered
//   i_evt_ready      consumer accepts the offered event
//   o_evt_channel    channel index of the offered event
//   o_evt_rising     1 = rising edge, 0 = falling edge
//   o_overflow       sticky per-channel flag: an event was dropped
//   i_overflow_clr   clears every o_overflow bit
module gpio_event_arbiter #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CH_W            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [CHANNELS-1:0] i_async,
    input  logic [CHANNELS-1:0] i_rise_en,
    input  logic [CHANNELS-1:0] i_fall_en,
    output logic [CHANNELS-1:0] o_level,
    output logic                o_evt_valid,
    input  logic                i_evt_ready,
    output logic [CH_W-1:0]     o_evt_channel,
    output logic                o_evt_rising,
    output logic [CHANNELS-1:0] o_overflow,
    input  logic                i_overflow_clr
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_OFFER
    } state_t;

    logic [CHANNELS-1:0] meta;
    logic [CHANNELS-1:0] sync;
    logic [CNT_W-1:0]    db_cnt [CHANNELS];
    logic [CHANNELS-1:0] done;
    logic [CHANNELS-1:0] rise_stb;
    logic [CHANNELS-1:0] fall_stb;
    logic [CHANNELS-1:0] qual_evt;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] pol;
    logic [CHANNELS-1:0] pending_nxt;
    logic [CHANNELS-1:0] pol_nxt;
    logic [CHANNELS-1:0] ovf_set;
    state_t              state;
    state_t              state_nxt;
    logic [CH_W-1:0]     ptr;
    logic [CH_W-1:0]     ptr_nxt;
    logic [CH_W-1:0]     chan_nxt;
    logic                rising_nxt;
    logic                handshake;
    logic                sel_found;
    logic [CH_W-1:0]     sel_ch;
    logic                sel_pol;

    // Two-flop synchronizer for the raw pins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= i_async;
            sync <= meta;
        end
    end

    // Debouncer. A level change is accepted only after the synchronized
    // value has differed from o_level for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_level <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                db_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (sync[c] == o_level[c]) begin
                    db_cnt[c] <= '0;
                end else if (db_cnt[c] == CNT_LAST) begin
                    o_level[c] <= sync[c];
                    db_cnt[c]  <= '0;
                end else begin
                    db_cnt[c] <= db_cnt[c] + 1'b1;
                end
            end
        end
    end

    // The edge strobe is combinational, so the pending bit sets on the same
    // clock edge that updates o_level.
    always_comb begin
        done = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            done[c] = (sync[c] != o_level[c]) && (db_cnt[c] == CNT_LAST);
        end
    end

    assign rise_stb  = done & sync;
    assign fall_stb  = done & ~sync;
    assign qual_evt  = (rise_stb & i_rise_en) | (fall_stb & i_fall_en);
    assign handshake = (state == ST_OFFER) && i_evt_ready;

    // Pending bookkeeping. A channel being handed off this cycle can take a
    // new event without loss. Otherwise a second event while one is already
    // held is dropped, and the older polarity is kept.
    always_comb begin
        pending_nxt = pending;
        pol_nxt     = pol;
        ovf_set     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (qual_evt[c]) begin
                if (!pending[c] || (handshake && (o_evt_channel == CH_W'(c)))) begin
                    pending_nxt[c] = 1'b1;
                    pol_nxt[c]     = rise_stb[c];
                end else begin
                    ovf_set[c] = 1'b1;
                end
            end else if (handshake && (o_evt_channel == CH_W'(c))) begin
                pending_nxt[c] = 1'b0;
            end
        end
    end

    // A newly dropped event takes precedence over a clear in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending    <= '0;
            pol        <= '0;
            o_overflow <= '0;
        end else begin
            pending    <= pending_nxt;
            pol        <= pol_nxt;
            o_overflow <= ovf_set | (i_overflow_clr ? '0 : o_overflow);
        end
    end

    // Round-robin search. Offsets are scanned from farthest to nearest, so
    // the last match is the first pending channel after the pointer.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        sel_pol   = 1'b0;
        for (int i = CHANNELS; i >= 1; i--) begin
            if (pending[(int'(ptr) + i) % CHANNELS]) begin
                sel_found = 1'b1;
                sel_ch    = CH_W'((int'(ptr) + i) % CHANNELS);
                sel_pol   = pol[(int'(ptr) + i) % CHANNELS];
            end
        end
    end

    // Arbiter state and offered-event registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= ST_IDLE;
            ptr           <= CH_W'(CHANNELS - 1);
            o_evt_channel <= '0;
            o_evt_rising  <= 1'b0;
        end else begin
            state         <= state_nxt;
            ptr           <= ptr_nxt;
            o_evt_channel <= chan_nxt;
            o_evt_rising  <= rising_nxt;
        end
    end

    // Next-state logic. The offer is held unchanged until it is accepted.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        chan_nxt   = o_evt_channel;
        rising_nxt = o_evt_rising;
        case (state)
            ST_IDLE: begin
                if (sel_found) begin
                    chan_nxt   = sel_ch;
                    rising_nxt = sel_pol;
                    state_nxt  = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (i_evt_ready) begin
                    ptr_nxt   = o_evt_channel;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign o_evt_valid = (state == ST_OFFER);

endmodule

// File: doc/gpio_event_arbiter.md
# gpio_event_arbiter

Multi-channel GPIO input event controller. Each asynchronous pin is brought into the `i_clk` domain through a two-flop synchronizer, then debounced. Each qualified rising or falling edge is latched as a pending event. One round-robin arbiter shares a single valid/ready event port among all channels. The block sits between the FPGA GPIO pins and the register/SPI interface that reports pin events to the ESP32 host.

## Interface
- `CHANNELS`, default 4: number of input pins. Range 1–16.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required to accept a level change. Must be ≥1.
- `CH_W`, default `$clog2(CHANNELS)` (minimum 1): width of the channel index.
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `i_async`  in  CHANNELS  raw, unsynchronized pin inputs.
- `i_rise_en`  in  CHANNELS  per-channel enable for rising-edge events.
- `i_fall_en`  in  CHANNELS  per-channel enable for falling-edge events.
- `o_level`  out  CHANNELS  debounced pin levels.
- `o_evt_valid`  out  1  event offered.
- `i_evt_ready`  in  1  consumer accepts the event.
- `o_evt_channel`  out  CH_W  channel index of the offered event.
- `o_evt_rising`  out  1  1 = rising edge, 0 = falling edge.
- `o_overflow`  out  CHANNELS  sticky per-channel flag: an event was dropped.
- `i_overflow_clr`  in  1  clears all `o_overflow` bits.

## Operation
- **Reset values.** All synchronizer flops 0, `o_level` 0, debounce counters 0, pending bits 0, `o_evt_valid` 0, `o_evt_channel` 0, `o_evt_rising` 0, `o_overflow` 0. The round-robin pointer resets to `CHANNELS-1`, so channel 0 has first priority.
- **Sync.** Per channel: `meta <= i_async`, then `sync <= meta`. This path has no reset-free flops.
- **Debounce.** Per channel, counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `sync == o_level`: counter is set to 0.
  - Else if counter equals `DEBOUNCE_CYCLES-1`: `o_level <= sync`, counter is set to 0, and an edge strobe fires for one cycle.
  - Else: counter increments.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles is discarded.
- **Qualify.** A rising strobe counts as an event only if `i_rise_en[ch]` is 1. A falling strobe counts only if `i_fall_en[ch]` is 1. The enables are sampled in the same cycle as the strobe.
- **Pending.** Each channel holds a pending bit and a polarity bit.
  - Qualified event while pending is 0: set pending and store the polarity.
  - Qualified event while pending is 1 and that channel is not completing a handshake this cycle: the new event is dropped, the stored polarity is kept (oldest wins), and `o_overflow[ch]` is set.
  - Qualified event in the same cycle as that channel's handshake: pending stays 1 with the new polarity. No overflow is flagged.
- **Arbiter FSM**, two states.
  - **IDLE:** `o_evt_valid` = 0. If any pending bit is set, select the first pending channel searching upward from pointer+1 with wrap-around. Register its index and polarity into `o_evt_channel` and `o_evt_rising`, set `o_evt_valid` = 1, and go to OFFER.
  - **OFFER:** `o_evt_valid`, `o_evt_channel` and `o_evt_rising` are held stable. When `o_evt_valid && i_evt_ready`, clear that channel's pending bit (subject to the same-cycle rule above), set pointer to the channel, drop `o_evt_valid`, and go to IDLE.
  - The offered channel keeps its pending bit set while in OFFER, so a further edge on it during OFFER counts as an overflow.
- **Overflow clear.** `i_overflow_clr` zeroes all `o_overflow` bits. A new overflow in the same cycle wins, and that bit stays 1.
- **Reset mid-operation.** Assertion immediately forces all reset values, including mid-debounce and mid-offer. Outstanding events are lost.

## Timing
- An input change first captured into `meta` at edge k reaches `sync` at k+1. `o_level` updates at edge k+1+DEBOUNCE_CYCLES.
- The pending bit sets at the same edge as the `o_level` update. `o_evt_valid` rises at the next edge: k+2+DEBOUNCE_CYCLES.
- Handshake rules:
  - `i_evt_ready` may be high before valid.
  - A transfer occurs on any edge where both are 1.
  - `o_evt_valid` never deasserts without a transfer.
- Maximum throughput is one event per 2 cycles.
- Round-robin is fair: a continuously pending channel waits at most `CHANNELS-1` grants.

## Test plan
- **Reset.** Hold `i_rst_n` = 0 with `i_async` = all 1 → all outputs 0. Release → `o_level` = all 1 after 2+16 cycles. With the enables at 0, no event is produced.
- **Debounce.** Enables all 1. Pulse ch1 high for 15 cycles → no `o_level` change and no event. Pulse it for 16 cycles → `o_level[1]` = 1, then `o_evt_valid` = 1 with channel = 1 and rising = 1.
- **Round-robin.** Raise ch0, ch2 and ch3 simultaneously with `i_evt_ready` = 1 → events are delivered in order 0, 2, 3, each `o_evt_valid` pulse 1 cycle wide, 2 cycles apart.
- **Backpressure and overflow.**
  - Step 1: `i_evt_ready` = 0. Ch2 rises, offered as rising.
  - Step 2: ch2 falls (debounced) while still offered → `o_overflow[2]` = 1. Outputs stay at channel = 2, rising = 1.
  - Step 3: `i_evt_ready` = 1 → transfer completes and no falling event follows.
  - Step 4: `i_overflow_clr` → `o_overflow` = 0.
- **Same-cycle event and handshake.** Align ch1's falling strobe with the handshake of ch1's rising event → no overflow. The next offer is channel = 1, rising = 0.
- **Async reset mid-offer.** Pulse `i_rst_n` low while `o_evt_valid` = 1 → outputs clear immediately without waiting for a clock. After release, pending is empty and no stale event appears.
